seg_digit_scanner: RTL
======================

# seg_digit_scanner

Upstream feeder for the `sevenSegment` decoder. It accepts a binary value and converts it to `NUM_DIGITS` BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a single 4-bit `bcd` bus, paired with a one-hot digit enable. `bcd` drives the decoder input directly, and `digit_en` drives the display common lines.

## Interface
- `NUM_DIGITS`, 4: number of display digits; legal range 1–6.
- `BIN_W`, 14: width of `value`; must satisfy 2^BIN_W ≥ 10^NUM_DIGITS.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit; must be ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: request to convert `value`; sampled only while `busy`=0.
- `value` input `BIN_W`: unsigned binary number to display.
- `busy` output 1: conversion in progress.
- `ovf` output 1: last accepted `value` exceeded 10^NUM_DIGITS−1.
- `bcd` output 4: digit code for the decoder; always in 0–9.
- `digit_en` output `NUM_DIGITS`: active-high, one-hot (or all-zero when blanked) digit select.

## Operation
- **Reset values:**
  - `busy`=0, `ovf`=0.
  - Display digit register = all 0.
  - Scan index = 0, refresh counter = 0.
  - Outputs: `bcd`=0, `digit_en`=1 (digit 0 only).
- **Conversion FSM**, states IDLE and CONV.
  - IDLE→CONV on `load`=1. On that edge:
    - Latch the operand.
    - Set `busy`=1 and clear the shift counter.
    - Saturate the operand: if `value` > 10^NUM_DIGITS−1, use 10^NUM_DIGITS−1 and set the pending-overflow flag; otherwise clear the flag.
  - CONV performs one double-dabble iteration per cycle: add 3 to every BCD nibble ≥ 5, then shift the combined register left by 1. It runs exactly `BIN_W` iterations.
  - On the edge completing iteration `BIN_W`:
    - Copy the BCD nibbles into the display digit register.
    - Copy the pending-overflow flag into `ovf`.
    - Set `busy`=0 and return to IDLE.
- `load` while `busy`=1 is ignored. It is not queued, and the operand does not change.
- The display register holds the previous digits throughout CONV, so no partially converted digits are ever shown.
- **Scanner** (free-running, independent of the FSM):
  - The refresh counter counts 0…`REFRESH_DIV`−1 and then wraps to 0.
  - On the wrap edge, the scan index advances by 1, wrapping from `NUM_DIGITS`−1 to 0.
  - `bcd` = display digit[scan index]; `digit_en` = one-hot(scan index), subject to blanking.
- Digit 0 is the least significant digit.

## Timing
- Load latency: `load` sampled high at edge t → `busy`=1 after t. The display register, `ovf` and `busy`=0 all update at edge t+`BIN_W`. With the defaults that is 14 cycles.
- The earliest next accepted `load` is sampled at edge t+`BIN_W`+1.
- `bcd` and `digit_en` are decoded combinationally from registered state (scan index, display register) and change only just after clock edges.
- New digits reach the outputs in the same cycle the display register updates.
- Each digit is enabled for exactly `REFRESH_DIV` cycles. The full frame is `NUM_DIGITS`×`REFRESH_DIV` cycles.
- `rst` mid-conversion aborts the conversion and returns everything to its reset values on the next edge. No partial result is committed.
- `load` and `rst` high together: reset wins.
- The scan index is not disturbed by a load or by a conversion.

## Configuration
- **`SEG_LZ_BLANK_EN` defined:** leading-zero blanking.
  - While scanning digit k > 0, `digit_en` = 0 if digit k and every more-significant digit are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - `bcd` still carries the digit value while blanked.
- **Not defined:** every digit is enabled in turn, including leading zeros.

## Structure
- Shared package `seg_pkg`:
  - `bcd_digit_t` (4-bit).
  - Default `NUM_DIGITS`.
  - FSM state enum (IDLE, CONV).
  - Constant function for 10^N−1.
- Sub-module `bin2bcd_dd`: the iterative double-dabble engine. It owns the shift register and iteration counter and has a start/done handshake. `seg_digit_scanner` instantiates it and owns saturation, the display register, the scanner and blanking.

## Test plan
- **Reset:** assert `rst` 3 cycles mid-scan → `busy`=0, `ovf`=0, `digit_en`=0001, `bcd`=0.
- **Basic load:** `value`=1234, `load` pulse → `busy` high 14 cycles. Then the scan with `REFRESH_DIV`=4 shows `bcd` 4,3,2,1 with `digit_en` 0001,0010,0100,1000, each held 4 cycles; `ovf`=0.
- **Saturation:** `value`=12000 → digits 9,9,9,9 and `ovf`=1. A subsequent `value`=5 → `ovf`=0.
- **Load while busy:** `load` with 4321, then `load` with 1111 two cycles later → display shows 4321 only; the second load is lost.
- **Reset mid-conversion:** load 9876 from displayed 1234, `rst` at cycle 5 → display all 0 and `busy`=0. No 9876 digits ever appear.
- **Leading-zero blanking:** value 7 with `SEG_LZ_BLANK_EN` → `digit_en` 0001 in slot 0 and 0000 in slots 1–3. Without the macro → all four slots enabled, `bcd` 7,0,0,0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types, defaults and constants for the seven-segment digit scanner
package seg_pkg;
   typedef logic [3:0] bcd_digit_t;
   localparam int DEF_NUM_DIGITS = 4;
   typedef enum logic {IDLE, CONV} conv_state_t;
   function automatic int unsigned pow10m1(input int n);
      int unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p - 1;
   endfunction
endpackage

// File: rtl/seg_digit_scanner_if.sv
// seg_digit_scanner_if: conversion request and multiplexed display bus
//   load/value   : request to convert an unsigned binary value (master -> slave)
//   busy/ovf     : conversion in progress / last value saturated (slave -> master)
//   bcd/digit_en : current digit code and one-hot digit select (slave -> master)
interface seg_digit_scanner_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W      = 14
);
   logic                  load;
   logic [BIN_W-1:0]      value;
   logic                  busy;
   logic                  ovf;
   logic [3:0]            bcd;
   logic [NUM_DIGITS-1:0] digit_en;
   modport master (output load, value, input busy, ovf, bcd, digit_en);
   modport slave (input load, value, output busy, ovf, bcd, digit_en);
endinterface

// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd: iterative double-dabble binary to BCD engine, one bit per cycle
//   start   : load operand and clear the iteration counter
//   en      : perform one add-3/shift iteration this cycle
//   done    : high during the final iteration; digits then holds the result
//   digits  : BCD value the register will hold after the current iteration
module bin2bcd_dd import seg_pkg::*; #(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int BIN_W      = 14
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        en,
   input  logic [BIN_W-1:0]            operand,
   output logic                        done,
   output bcd_digit_t [NUM_DIGITS-1:0] digits
);
   localparam int SW = 4 * NUM_DIGITS + BIN_W;
   localparam int CW = $clog2(BIN_W + 1);
   logic [SW-1:0] sr, adj, nxt;
   logic [CW-1:0] cnt;
   always_comb begin
      adj = sr;
      for (int i = 0; i < NUM_DIGITS; i++)
         adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] >= 4'd5 ? sr[BIN_W+4*i +: 4] + 4'd3 : sr[BIN_W+4*i +: 4];
   end
   assign nxt    = adj << 1;
   assign digits = nxt[SW-1:BIN_W];
   assign done   = en && cnt == CW'(BIN_W - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (start) begin
         sr  <= SW'(operand);
         cnt <= '0;
      end else if (en) begin
         sr  <= nxt;
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: binary to BCD conversion plus time-multiplexed digit scan
//   clk/rst : clock, synchronous active-high reset
//   bus     : seg_digit_scanner_if slave (load/value in; busy/ovf/bcd/digit_en out)
//   Define SEG_LZ_BLANK_EN to blank leading-zero digits (digit 0 is never blanked).
module seg_digit_scanner import seg_pkg::*; #(
   parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int BIN_W       = 14,
   parameter int REFRESH_DIV = 50000
) (
   input logic                clk,
   input logic                rst,
   seg_digit_scanner_if.slave bus
);
   localparam logic [BIN_W-1:0] MAXV = BIN_W'(pow10m1(NUM_DIGITS));
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int RW = $clog2(REFRESH_DIV);
   conv_state_t                 state_q, state_d;
   logic                        start, done, pend, ovf_q, over;
   bcd_digit_t [NUM_DIGITS-1:0] disp, res;
   logic [IW-1:0]               idx;
   logic [RW-1:0]               rcnt;
   logic [NUM_DIGITS-1:0]       onehot;
   assign over  = bus.value > MAXV;
   assign start = state_q == IDLE && bus.load;
   always_comb begin
      state_d = state_q;
      state_d = state_q == IDLE ? (bus.load ? CONV : IDLE) : (done ? IDLE : CONV);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend    <= 1'b0;
         ovf_q   <= 1'b0;
         disp    <= '0;
      end else begin
         state_q <= state_d;
         if (start) pend <= over;
         if (done) begin
            disp  <= res;
            ovf_q <= pend;
         end
      end
   end
   bin2bcd_dd #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) u_dd (
      .clk(clk),
      .rst(rst),
      .start(start),
      .en(state_q == CONV),
      .operand(over ? MAXV : bus.value),
      .done(done),
      .digits(res)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt <= '0;
         idx  <= '0;
      end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
         rcnt <= '0;
         idx  <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end
   assign onehot   = NUM_DIGITS'(1) << idx;
   assign bus.busy = state_q == CONV;
   assign bus.ovf  = ovf_q;
   assign bus.bcd  = disp[idx];
`ifdef SEG_LZ_BLANK_EN
   // lz[k]: digit k and every more-significant digit are zero
   logic [NUM_DIGITS-1:0] lz;
   logic                  acc;
   always_comb begin
      lz  = '0;
      acc = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         acc   = acc && disp[k] == 4'd0;
         lz[k] = acc;
      end
   end
   assign bus.digit_en = idx != '0 && lz[idx] ? '0 : onehot;
`else
   assign bus.digit_en = onehot;
`endif
endmodule
